// File: rtl/vmask_pkg.sv
// Shared types and default geometry for the vcpop.m / vfirst.m mask sequencer.
// Optional vfirst.m support is enabled with VMASK_VFIRST_EN.
package vmask_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_VLEN       = 512;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_VL_WIDTH   = 10;
  localparam int DEF_PIPE_LAT   = 3;
  localparam int DEF_RES_WIDTH  = 64;

  localparam int SLICES   = DEF_DATA_WIDTH / 8;
  localparam int WORDS    = DEF_VLEN / DEF_DATA_WIDTH;
  localparam int SLICE_IW = $clog2(SLICES);
  localparam int WORD_IW  = $clog2(WORDS);
  localparam int BIT_IW   = $clog2(DEF_DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SLICE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/vmask_slice_sel.sv
// Tail/v0 masking of a fetched mask word, slice count of the word,
// and the 8-bit slice mux feeding the popcount datapath.
module vmask_slice_sel
  import vmask_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VL_WIDTH   = DEF_VL_WIDTH,
  parameter int WIW        = WORD_IW,
  parameter int SIW        = SLICE_IW
) (
  input  logic [DATA_WIDTH-1:0] vs2_i,
  input  logic [DATA_WIDTH-1:0] v0_i,
  input  logic                  vm_i,
  input  logic [VL_WIDTH-1:0]   vl_i,
  input  logic [WIW-1:0]        idx_i,
  input  logic [DATA_WIDTH-1:0] buf_i,
  input  logic [SIW-1:0]        k_i,
  output logic [DATA_WIDTH-1:0] masked_o,
  output logic [7:0]            slice_o,
  output logic [SIW-1:0]        last_k_o
);

  localparam int DWL = $clog2(DATA_WIDTH);
  localparam int EW  = VL_WIDTH + 2;

  logic [EW-1:0]         base;
  logic [EW-1:0]         rem;
  logic [EW-1:0]         nsl;
  logic [DATA_WIDTH-1:0] tail;

  always_comb begin
    base = EW'(idx_i) << DWL;
    rem  = EW'(vl_i) - base;
    nsl  = (rem + EW'(7)) >> 3;
    tail = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      tail[b] = (base + EW'(b)) < EW'(vl_i);
    end
    masked_o = vs2_i & (vm_i ? {DATA_WIDTH{1'b1}} : v0_i) & tail;
    // a partial last word only needs the slices that hold live elements
    if (rem >= EW'(DATA_WIDTH)) begin
      last_k_o = SIW'(DATA_WIDTH / 8 - 1);
    end else begin
      last_k_o = SIW'(nsl - EW'(1));
    end
    slice_o = buf_i[{k_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/vmask_cpop_ctrl.sv
// Mask popcount sequencer: fetches vs2 (and v0) words, issues 8-bit slices,
// accumulates datapath results. VMASK_VFIRST_EN adds vfirst.m via req_first.
module vmask_cpop_ctrl
  import vmask_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int VLEN       = DEF_VLEN,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int VL_WIDTH   = DEF_VL_WIDTH,
  parameter int PIPE_LAT   = DEF_PIPE_LAT,
  parameter int RES_WIDTH  = DEF_RES_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_WIDTH-1:0]                 req_vs2,
  input  logic [VL_WIDTH-1:0]                   req_vl,
  input  logic                                  req_vm,
`ifdef VMASK_VFIRST_EN
  input  logic                                  req_first,
`endif
  output logic                                  rd_en,
  output logic [ADDR_WIDTH-1:0]                 rd_reg,
  output logic [$clog2(VLEN/DATA_WIDTH)-1:0]    rd_idx,
  input  logic [DATA_WIDTH-1:0]                 rd_data,
  input  logic [DATA_WIDTH-1:0]                 rd_v0_data,
  output logic [7:0]                            pc_m0,
  output logic                                  pc_valid,
  output logic [RES_WIDTH-1:0]                  pc_count,
  input  logic [RES_WIDTH-1:0]                  pc_result,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [RES_WIDTH-1:0]                  resp_data
);

  localparam int NSL = DATA_WIDTH / 8;
  localparam int NWD = VLEN / DATA_WIDTH;
  localparam int SIW = $clog2(NSL);
  localparam int WIW = $clog2(NWD);
  localparam int DWL = $clog2(DATA_WIDTH);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   vs2_q;
  logic [VL_WIDTH-1:0]     vl_q;
  logic [VL_WIDTH-1:0]     vl_d;
  logic                    vm_q;
  logic [WIW-1:0]          idx_q;
  logic [SIW-1:0]          slice_q;
  logic [DATA_WIDTH-1:0]   word_buf_q;
  logic [RES_WIDTH-1:0]    acc_q;
  logic [PIPE_LAT-1:0]     pipe_q;
  logic                    req_ready_q;
  logic                    rd_en_q;
  logic                    pc_valid_q;
  logic [7:0]              pc_m0_q;
  logic                    resp_valid_q;

  logic [WIW-1:0]          last_word;
  logic [DATA_WIDTH-1:0]   masked;
  logic [DATA_WIDTH-1:0]   sel_buf;
  logic [SIW-1:0]          sel_k;
  logic [7:0]              sel_slice;
  logic [SIW-1:0]          last_k;
  logic                    drain_ok;

`ifdef VMASK_VFIRST_EN
  logic                    first_q;
  logic [DWL-1:0]          first_pos;

  always_comb begin
    first_pos = '0;
    for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
      if (masked[b]) first_pos = DWL'(b);
    end
  end
`endif

  assign vl_d      = (req_vl > VL_WIDTH'(VLEN)) ? VL_WIDTH'(VLEN) : req_vl;
  assign last_word = WIW'((vl_q - VL_WIDTH'(1)) >> DWL);
  // in LOAD the next slice comes straight from the incoming word
  assign sel_buf   = (state_q == LOAD) ? masked : word_buf_q;
  assign sel_k     = (state_q == LOAD) ? '0 : slice_q + SIW'(1);
  // the last stage retires on the edge that leaves DRAIN
  assign drain_ok  = (pipe_q[PIPE_LAT-2:0] == '0);

  vmask_slice_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .VL_WIDTH   (VL_WIDTH),
    .WIW        (WIW),
    .SIW        (SIW)
  ) u_sel (
    .vs2_i    (rd_data),
    .v0_i     (rd_v0_data),
    .vm_i     (vm_q),
    .vl_i     (vl_q),
    .idx_i    (idx_q),
    .buf_i    (sel_buf),
    .k_i      (sel_k),
    .masked_o (masked),
    .slice_o  (sel_slice),
    .last_k_o (last_k)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      vs2_q        <= '0;
      vl_q         <= '0;
      vm_q         <= 1'b0;
      idx_q        <= '0;
      slice_q      <= '0;
      word_buf_q   <= '0;
      acc_q        <= '0;
      pipe_q       <= '0;
      req_ready_q  <= 1'b1;
      rd_en_q      <= 1'b0;
      pc_valid_q   <= 1'b0;
      pc_m0_q      <= '0;
      resp_valid_q <= 1'b0;
`ifdef VMASK_VFIRST_EN
      first_q      <= 1'b0;
`endif
    end else begin
      pipe_q <= {pipe_q[PIPE_LAT-2:0], pc_valid_q};
      if (pipe_q[PIPE_LAT-1]) acc_q <= acc_q + pc_result;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            vs2_q       <= req_vs2;
            vl_q        <= vl_d;
            vm_q        <= req_vm;
            idx_q       <= '0;
            slice_q     <= '0;
            acc_q       <= '0;
            req_ready_q <= 1'b0;
`ifdef VMASK_VFIRST_EN
            first_q     <= req_first;
            if (req_first) acc_q <= '1;
`endif
            if (vl_d == '0) begin
              state_q <= DRAIN;
            end else begin
              state_q <= FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= LOAD;
        end
        LOAD: begin
          word_buf_q <= masked;
`ifdef VMASK_VFIRST_EN
          if (first_q) begin
            if (|masked) begin
              acc_q        <= RES_WIDTH'({idx_q, first_pos});
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
            end else if (idx_q == last_word) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
            end else begin
              idx_q   <= idx_q + WIW'(1);
              rd_en_q <= 1'b1;
              state_q <= FETCH;
            end
          end else begin
`endif
            state_q    <= SLICE;
            slice_q    <= '0;
            pc_valid_q <= 1'b1;
            pc_m0_q    <= sel_slice;
`ifdef VMASK_VFIRST_EN
          end
`endif
        end
        SLICE: begin
          if (slice_q == last_k) begin
            pc_valid_q <= 1'b0;
            pc_m0_q    <= '0;
            if (idx_q == last_word) begin
              state_q <= DRAIN;
            end else begin
              idx_q   <= idx_q + WIW'(1);
              rd_en_q <= 1'b1;
              state_q <= FETCH;
            end
          end else begin
            slice_q <= slice_q + SIW'(1);
            pc_m0_q <= sel_slice;
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rd_en      = rd_en_q;
  assign rd_reg     = vs2_q;
  assign rd_idx     = idx_q;
  assign pc_m0      = pc_m0_q;
  assign pc_valid   = pc_valid_q;
  assign pc_count   = '0;
  assign resp_valid = resp_valid_q;
  assign resp_data  = acc_q;

endmodule
